// File: rtl/wts_channel_scheduler_pkg.sv
// Shared definitions for the WTS envelope scheduler: channel count, no-op slot code,
// pending key-kind encoding and the per-channel request priority helpers.
package wts_channel_scheduler_pkg;

  localparam int unsigned WTS_NUM_CH   = 5;
  localparam logic [2:0]  WTS_SLOT_NOP = 3'd5;

  typedef enum logic [1:0] {
    WTS_KEY_NONE    = 2'd0,
    WTS_KEY_ON      = 2'd1,
    WTS_KEY_RELEASE = 2'd2,
    WTS_KEY_OFF     = 2'd3
  } key_kind_t;

  // Simultaneous requests resolve off > on > release; the rest are dropped.
  function automatic key_kind_t resolve_key_req(input logic on_req, input logic release_req,
                                                input logic off_req);
    key_kind_t kind;
    kind = WTS_KEY_NONE;
    if (off_req) begin
      kind = WTS_KEY_OFF;
    end else if (on_req) begin
      kind = WTS_KEY_ON;
    end else if (release_req) begin
      kind = WTS_KEY_RELEASE;
    end
    return kind;
  endfunction

  // One-hot pending vector: bit0 = on, bit1 = release, bit2 = off.
  function automatic logic [2:0] key_onehot(input key_kind_t kind);
    logic [2:0] oh;
    oh = 3'b000;
    unique case (kind)
      WTS_KEY_ON:      oh = 3'b001;
      WTS_KEY_RELEASE: oh = 3'b010;
      WTS_KEY_OFF:     oh = 3'b100;
      default:         oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/wts_key_event_latch.sv
// One channel's key-event latch: priority resolve, one-hot pending register and clear on
// service. A request in the service cycle wins over the clear.
module wts_key_event_latch
  import wts_channel_scheduler_pkg::*;
(
  input  logic clk,
  input  logic nreset,
  input  logic on_req,
  input  logic release_req,
  input  logic off_req,
  input  logic service,
  output logic key_on,
  output logic key_release,
  output logic key_off
);

  logic [2:0] pending_q, pending_d;
  key_kind_t  req_kind;

  always_comb begin
    req_kind  = resolve_key_req(on_req, release_req, off_req);
    pending_d = pending_q;
    if (service) begin
      pending_d = 3'b000;
    end
    if (req_kind != WTS_KEY_NONE) begin
      pending_d = key_onehot(req_kind);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pending_q <= 3'b000;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign key_on      = pending_q[0];
  assign key_release = pending_q[1];
  assign key_off     = pending_q[2];

endmodule

// File: rtl/wts_channel_scheduler.sv
// Time-slot scheduler and key-event latches for the 5-channel ADSR envelope generator.
// Optional freeze input is enabled by defining WTS_SCHEDULER_FREEZE_EN.
module wts_channel_scheduler
  import wts_channel_scheduler_pkg::*;
#(
  parameter int unsigned IDLE_SLOTS = 1
) (
  input  logic       clk,
  input  logic       nreset,
`ifdef WTS_SCHEDULER_FREEZE_EN
  input  logic       freeze,
`endif
  input  logic [4:0] key_on_req,
  input  logic [4:0] key_release_req,
  input  logic [4:0] key_off_req,
  output logic [2:0] active,
  output logic       frame_start,
  output logic [4:0] ch_key_on,
  output logic [4:0] ch_key_release,
  output logic [4:0] ch_key_off
);

  localparam logic [3:0] IdleLast = 4'(IDLE_SLOTS - 1);

  logic [2:0] active_q, active_d;
  logic       frame_start_q, frame_start_d;
  logic [3:0] idle_cnt_q, idle_cnt_d;
  logic [2:0] step_slot;
  logic [3:0] step_idle;
  logic       service_en;

  // Free-running successor of the current slot.
  always_comb begin
    step_slot = active_q;
    step_idle = idle_cnt_q;
    if (active_q < 3'd4) begin
      step_slot = active_q + 3'd1;
    end else if (active_q == 3'd4) begin
      step_slot = WTS_SLOT_NOP;
      step_idle = 4'd0;
    end else if (active_q != WTS_SLOT_NOP || idle_cnt_q == IdleLast) begin
      step_slot = 3'd0;
    end else begin
      step_idle = idle_cnt_q + 4'd1;
    end
  end

`ifdef WTS_SCHEDULER_FREEZE_EN
  logic       frozen_q;
  logic [2:0] held_q, held_d;

  // On freeze entry the successor slot and its idle count are captured; while frozen
  // active is forced to no-op and the captured position is released on freeze falling.
  always_comb begin
    active_d   = step_slot;
    idle_cnt_d = step_idle;
    held_d     = held_q;
    service_en = ~freeze;
    if (freeze) begin
      active_d = WTS_SLOT_NOP;
      if (!frozen_q) begin
        held_d = step_slot;
      end else begin
        idle_cnt_d = idle_cnt_q;
      end
    end else if (frozen_q) begin
      active_d   = held_q;
      idle_cnt_d = idle_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      frozen_q <= 1'b0;
      held_q   <= 3'd0;
    end else begin
      frozen_q <= freeze;
      held_q   <= held_d;
    end
  end
`else
  always_comb begin
    active_d   = step_slot;
    idle_cnt_d = step_idle;
    service_en = 1'b1;
  end
`endif

  assign frame_start_d = (active_d == 3'd0);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      active_q      <= WTS_SLOT_NOP;
      frame_start_q <= 1'b0;
      idle_cnt_q    <= IdleLast;
    end else begin
      active_q      <= active_d;
      frame_start_q <= frame_start_d;
      idle_cnt_q    <= idle_cnt_d;
    end
  end

  assign active      = active_q;
  assign frame_start = frame_start_q;

  for (genvar n = 0; n < WTS_NUM_CH; n++) begin : g_ch
    wts_key_event_latch u_latch (
      .clk         (clk),
      .nreset      (nreset),
      .on_req      (key_on_req[n]),
      .release_req (key_release_req[n]),
      .off_req     (key_off_req[n]),
      .service     (service_en & (active_q == 3'(n))),
      .key_on      (ch_key_on[n]),
      .key_release (ch_key_release[n]),
      .key_off     (ch_key_off[n])
    );
  end

endmodule

// File: tb/tb_wts_channel_scheduler.sv
// Directed bench for wts_channel_scheduler: slot sequence for IDLE_SLOTS 1 and 3, key latch
// table, async reset mid-frame and (when WTS_SCHEDULER_FREEZE_EN is defined) freeze.
module tb_wts_channel_scheduler;

  logic       clk;
  logic       nreset;
  logic       freeze;
  logic [4:0] on_req, rel_req, off_req;
  logic [2:0] active, active3;
  logic       fs, fs3;
  logic [4:0] k_on, k_rel, k_off, k_on3, k_rel3, k_off3;

  int checks = 0;
  int errors = 0;

  wts_channel_scheduler dut (
    .clk             (clk),
    .nreset          (nreset),
`ifdef WTS_SCHEDULER_FREEZE_EN
    .freeze          (freeze),
`endif
    .key_on_req      (on_req),
    .key_release_req (rel_req),
    .key_off_req     (off_req),
    .active          (active),
    .frame_start     (fs),
    .ch_key_on       (k_on),
    .ch_key_release  (k_rel),
    .ch_key_off      (k_off)
  );

  wts_channel_scheduler #(.IDLE_SLOTS(3)) dut3 (
    .clk             (clk),
    .nreset          (nreset),
`ifdef WTS_SCHEDULER_FREEZE_EN
    .freeze          (1'b0),
`endif
    .key_on_req      (5'b0),
    .key_release_req (5'b0),
    .key_off_req     (5'b0),
    .active          (active3),
    .frame_start     (fs3),
    .ch_key_on       (k_on3),
    .ch_key_release  (k_rel3),
    .ch_key_off      (k_off3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] on;
    logic [4:0] rel;
    logic [4:0] off;
    logic [2:0] act;
    logic       fs;
    logic [4:0] e_on;
    logic [4:0] e_rel;
    logic [4:0] e_off;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic [4:0] on, input logic [4:0] rel, input logic [4:0] off,
                              input logic [2:0] act, input logic [4:0] e_on,
                              input logic [4:0] e_rel, input logic [4:0] e_off);
    vec_t v;
    v.on = on; v.rel = rel; v.off = off; v.act = act; v.fs = (act == 3'd0);
    v.e_on = e_on; v.e_rel = e_rel; v.e_off = e_off;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [2:0] a, input logic [4:0] e_on,
                           input logic [4:0] e_rel, input logic [4:0] e_off);
    chk({tag, ".active"}, 32'(active), 32'(a));
    chk({tag, ".frame_start"}, 32'(fs), 32'(a == 3'd0));
    chk({tag, ".keys"}, 32'({k_on, k_rel, k_off}), 32'({e_on, e_rel, e_off}));
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.active", 32'(active), 32'd5);
    chk("rst.frame_start", 32'(fs), 32'd0);
    chk("rst.keys", 32'({k_on, k_rel, k_off}), 32'd0);
    chk("rst.active3", 32'(active3), 32'd5);
    nreset = 1'b1;
  endtask

  initial begin
    logic [2:0] e1, e3;
    nreset = 1'b0;
    freeze = 1'b0;
    on_req = '0; rel_req = '0; off_req = '0;

    // Free-running sequence, IDLE_SLOTS 1 and 3
    do_reset();
    for (int k = 0; k < 32; k++) begin
      tick();
      e1 = 3'(k % 6);
      e3 = ((k % 8) < 5) ? 3'(k % 8) : 3'd5;
      chk($sformatf("seq1[%0d]", k), 32'({active, fs}), 32'({e1, e1 == 3'd0}));
      chk($sformatf("seq3[%0d]", k), 32'({active3, fs3}), 32'({e3, e3 == 3'd0}));
      chk($sformatf("seq.keys[%0d]", k), 32'({k_on, k_rel, k_off, k_on3, k_rel3, k_off3}), 32'd0);
    end

    // Key latch table
    vq.push_back(mk(5'b00000, 5'b00000, 5'b00000, 3'd0, 5'b00000, 5'b00000, 5'b00000));
    vq.push_back(mk(5'b00000, 5'b00000, 5'b00000, 3'd1, 5'b00000, 5'b00000, 5'b00000));
    vq.push_back(mk(5'b00000, 5'b00000, 5'b00000, 3'd2, 5'b00000, 5'b00000, 5'b00000));
    vq.push_back(mk(5'b00000, 5'b00000, 5'b00000, 3'd3, 5'b00000, 5'b00000, 5'b00000));
    vq.push_back(mk(5'b00000, 5'b00000, 5'b00000, 3'd4, 5'b00000, 5'b00000, 5'b00000));
    vq.push_back(mk(5'b00100, 5'b00000, 5'b00000, 3'd5, 5'b00100, 5'b00000, 5'b00000));
    vq.push_back(mk(5'b00000, 5'b00000, 5'b00000, 3'd0, 5'b00100, 5'b00000, 5'b00000));
    vq.push_back(mk(5'b00000, 5'b00000, 5'b00000, 3'd1, 5'b00100, 5'b00000, 5'b00000));
    vq.push_back(mk(5'b00000, 5'b00000, 5'b00000, 3'd2, 5'b00100, 5'b00000, 5'b00000));
    vq.push_back(mk(5'b00000, 5'b00000, 5'b00000, 3'd3, 5'b00000, 5'b00000, 5'b00000));
    vq.push_back(mk(5'b00010, 5'b00000, 5'b00010, 3'd4, 5'b00000, 5'b00000, 5'b00010));
    vq.push_back(mk(5'b00000, 5'b00010, 5'b00000, 3'd5, 5'b00000, 5'b00010, 5'b00000));
    vq.push_back(mk(5'b00000, 5'b00000, 5'b00000, 3'd0, 5'b00000, 5'b00010, 5'b00000));
    vq.push_back(mk(5'b00000, 5'b00000, 5'b00000, 3'd1, 5'b00000, 5'b00010, 5'b00000));
    vq.push_back(mk(5'b00000, 5'b00000, 5'b00000, 3'd2, 5'b00000, 5'b00000, 5'b00000));
    vq.push_back(mk(5'b00000, 5'b00000, 5'b00001, 3'd3, 5'b00000, 5'b00000, 5'b00001));
    vq.push_back(mk(5'b00000, 5'b00000, 5'b00000, 3'd4, 5'b00000, 5'b00000, 5'b00001));
    vq.push_back(mk(5'b00000, 5'b00000, 5'b00000, 3'd5, 5'b00000, 5'b00000, 5'b00001));
    vq.push_back(mk(5'b00000, 5'b00000, 5'b00000, 3'd0, 5'b00000, 5'b00000, 5'b00001));
    vq.push_back(mk(5'b00001, 5'b00000, 5'b00000, 3'd1, 5'b00001, 5'b00000, 5'b00000));
    vq.push_back(mk(5'b00000, 5'b00000, 5'b00000, 3'd2, 5'b00001, 5'b00000, 5'b00000));
    vq.push_back(mk(5'b00000, 5'b00000, 5'b00000, 3'd3, 5'b00001, 5'b00000, 5'b00000));
    vq.push_back(mk(5'b00000, 5'b00000, 5'b00000, 3'd4, 5'b00001, 5'b00000, 5'b00000));
    vq.push_back(mk(5'b00000, 5'b00000, 5'b00000, 3'd5, 5'b00001, 5'b00000, 5'b00000));
    vq.push_back(mk(5'b00000, 5'b00000, 5'b00000, 3'd0, 5'b00001, 5'b00000, 5'b00000));
    vq.push_back(mk(5'b00000, 5'b00000, 5'b00000, 3'd1, 5'b00000, 5'b00000, 5'b00000));
    vq.push_back(mk(5'b10000, 5'b10000, 5'b10000, 3'd2, 5'b00000, 5'b00000, 5'b10000));
    vq.push_back(mk(5'b10000, 5'b10000, 5'b00000, 3'd3, 5'b10000, 5'b00000, 5'b00000));
    vq.push_back(mk(5'b00000, 5'b00000, 5'b00000, 3'd4, 5'b10000, 5'b00000, 5'b00000));
    vq.push_back(mk(5'b00000, 5'b00000, 5'b00000, 3'd5, 5'b00000, 5'b00000, 5'b00000));

    do_reset();
    for (int i = 0; i < vq.size(); i++) begin
      on_req = vq[i].on; rel_req = vq[i].rel; off_req = vq[i].off;
      tick();
      on_req = '0; rel_req = '0; off_req = '0;
      chk_state($sformatf("vec[%0d]", i), vq[i].act, vq[i].e_on, vq[i].e_rel, vq[i].e_off);
    end

    // Async reset at active==3 with B and E pending
    rel_req = 5'b10000;
    tick();
    rel_req = '0;
    chk_state("mr.a0", 3'd0, 5'b00000, 5'b10000, 5'b00000);
    tick();
    tick();
    on_req = 5'b00010;
    tick();
    on_req = '0;
    chk_state("mr.a3", 3'd3, 5'b00010, 5'b10000, 5'b00000);
    #2 nreset = 1'b0;
    #1;
    chk_state("mr.async", 3'd5, 5'b00000, 5'b00000, 5'b00000);
    @(posedge clk);
    @(negedge clk);
    nreset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk_state($sformatf("mr.post[%0d]", k), 3'(k), 5'b00000, 5'b00000, 5'b00000);
    end

`ifdef WTS_SCHEDULER_FREEZE_EN
    // Freeze with active==1 for 4 edges; key_on for D arrives mid-freeze
    tick();
    tick();
    chk_state("fz.pre", 3'd1, 5'b00000, 5'b00000, 5'b00000);
    freeze = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) on_req = 5'b01000;
      tick();
      on_req = '0;
      chk_state($sformatf("fz.hold[%0d]", k), 3'd5, (k >= 1) ? 5'b01000 : 5'b00000,
                5'b00000, 5'b00000);
    end
    freeze = 1'b0;
    tick();
    chk_state("fz.r2", 3'd2, 5'b01000, 5'b00000, 5'b00000);
    tick();
    chk_state("fz.r3", 3'd3, 5'b01000, 5'b00000, 5'b00000);
    tick();
    chk_state("fz.r4", 3'd4, 5'b00000, 5'b00000, 5'b00000);
    tick();
    chk_state("fz.r5", 3'd5, 5'b00000, 5'b00000, 5'b00000);
    tick();
    chk_state("fz.r0", 3'd0, 5'b00000, 5'b00000, 5'b00000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
